// File: rtl/lu_arbiter.sv
// lu_arbiter: two-requester round-robin arbiter and sequencer for a shared AND/NAND/OR/NOR unit
module lu_arbiter #(
  parameter int W   = 4,
  parameter int LAT = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req0,
  input  logic [1:0]   op0,
  input  logic [W-1:0] a0,
  input  logic [W-1:0] b0,
  input  logic         req1,
  input  logic [1:0]   op1,
  input  logic [W-1:0] a1,
  input  logic [W-1:0] b1,
  output logic         gnt0,
  output logic         gnt1,
  output logic         done0,
  output logic         done1,
  output logic [W-1:0] result,
  output logic         busy
);
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  state_t state, state_n;
  logic [3:0] cnt;
  logic idx, last, win;
  logic [1:0] op_q;
  logic [W-1:0] a_q, b_q, t, f;
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      idx    <= 1'b0;
      last   <= 1'b1;
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      result <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && (req0 || req1)) begin
        idx  <= win;
        op_q <= win ? op1 : op0;
        a_q  <= win ? a1 : a0;
        b_q  <= win ? b1 : b0;
        cnt  <= 4'(LAT - 1);
      end
      if (state == EXEC) begin
        cnt <= cnt - 4'd1;
        if (cnt == 4'd0) begin
          result <= f;
          last   <= idx;
        end
      end
    end
  end
  always_comb begin
    win     = (req0 && req1) ? ~last : req1;
    state_n = state == IDLE ? ((req0 || req1) ? EXEC : IDLE) :
              state == EXEC ? ((cnt == 4'd0) ? DONE : EXEC) : IDLE;
  end
  always_comb begin
    t = op_q[1] ? (a_q | b_q) : (a_q & b_q);
    f = op_q[0] ? ~t : t;
  end
  always_comb begin
    gnt0  = state == EXEC && !idx;
    gnt1  = state == EXEC && idx;
    done0 = state == DONE && !idx;
    done1 = state == DONE && idx;
    busy  = state != IDLE;
  end
endmodule

// File: tb/tb_lu_arbiter.sv
// tb_lu_arbiter: directed and randomized self-checking bench for lu_arbiter
module tb_lu_arbiter;
  localparam int W = 4;
  localparam int LAT = 2;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic req0 = 1'b0, req1 = 1'b0;
  logic [1:0] op0 = '0, op1 = '0;
  logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic gnt0, gnt1, done0, done1, busy;
  logic [W-1:0] result;
  logic [W+4:0] obs, exp_v;
  int checks = 0;
  int errors = 0;
  int m_ph = -1;
  logic m_who = 1'b0, m_last = 1'b1;
  logic [W-1:0] m_res = '0, m_out = '0;

  lu_arbiter #(.W(W), .LAT(LAT)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .op0(op0), .a0(a0), .b0(b0),
    .req1(req1), .op1(op1), .a1(a1), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .result(result), .busy(busy)
  );

  always #5 clk = ~clk;
  assign obs = {gnt0, gnt1, done0, done1, busy, result};

  function automatic logic [W-1:0] lu_ref(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      2'd0: return a & b;
      2'd1: return ~(a & b);
      2'd2: return a | b;
      default: return ~(a | b);
    endcase
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_ph = -1;
      m_last = 1'b1;
      m_out = '0;
    end else if (m_ph < 0) begin
      if (req0 || req1) begin
        m_who = (req0 && req1) ? !m_last : req1;
        m_res = m_who ? lu_ref(op1, a1, b1) : lu_ref(op0, a0, b0);
        m_ph = 0;
      end
    end else if (m_ph == LAT) begin
      m_ph = -1;
    end else begin
      m_ph++;
      if (m_ph == LAT) begin
        m_out = m_res;
        m_last = m_who;
      end
    end
  end

  task automatic test_reset;
    reset = 1'b1; req0 = 1'b1; req1 = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if (obs !== '0) begin errors++; $display("FAIL reset_hold cycle %0d: got %b want 0", k, obs); end
    end
    reset = 1'b0;
    @(negedge clk);
    exp_v = {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL reset_first_grant: got %b want %b", obs, exp_v); end
    req0 = 1'b0; req1 = 1'b0; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_nand;
    req0 = 1'b1; op0 = 2'b01; a0 = 4'b1100; b0 = 4'b1010;
    for (int k = 0; k < LAT + 2; k++) begin
      @(negedge clk);
      exp_v = {k < LAT, 1'b0, k == LAT, 1'b0, k <= LAT, (k >= LAT) ? 4'b0111 : 4'h0};
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL nand cycle %0d: got %b want %b", k, obs, exp_v); end
      req0 = 1'b0;
    end
  endtask

  task automatic test_both;
    int p, n, ld;
    logic who;
    logic [W-1:0] r;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    req0 = 1'b1; op0 = 2'b00; a0 = 4'b1100; b0 = 4'b1010;
    req1 = 1'b1; op1 = 2'b10; a1 = 4'b1100; b1 = 4'b1010;
    for (int k = 0; k < 3 * (LAT + 2); k++) begin
      @(negedge clk);
      p = k % (LAT + 2);
      n = k / (LAT + 2);
      who = n[0];
      ld = (p >= LAT) ? n : n - 1;
      r = (ld < 0) ? 4'h0 : (ld % 2 == 1) ? 4'b1110 : 4'b1000;
      exp_v = {p < LAT && !who, p < LAT && who, p == LAT && !who, p == LAT && who, p <= LAT, r};
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL both cycle %0d: got %b want %b", k, obs, exp_v); end
    end
    req0 = 1'b0; req1 = 1'b0;
  endtask

  task automatic test_input_change;
    req0 = 1'b1; op0 = 2'b10; a0 = 4'b0001; b0 = 4'b0010;
    for (int k = 0; k < LAT + 2; k++) begin
      @(negedge clk);
      exp_v = {k < LAT, 1'b0, k == LAT, 1'b0, k <= LAT, (k >= LAT) ? 4'b0011 : 4'b1000};
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL input_change cycle %0d: got %b want %b", k, obs, exp_v); end
      a0 = 4'b1111; op0 = 2'b01; req0 = 1'b0;
    end
  endtask

  task automatic test_reset_mid;
    req1 = 1'b1; op1 = 2'b00; a1 = 4'hF; b1 = 4'hF;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      exp_v = {1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0011};
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL reset_mid exec %0d: got %b want %b", k, obs, exp_v); end
    end
    reset = 1'b1; req1 = 1'b0;
    @(negedge clk);
    checks++;
    if (obs !== '0) begin errors++; $display("FAIL reset_mid abort: got %b want 0", obs); end
    reset = 1'b0; req0 = 1'b1; req1 = 1'b1; a0 = 4'h0; b0 = 4'h0; op0 = 2'b00;
    @(negedge clk);
    exp_v = {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL reset_mid regrant: got %b want %b", obs, exp_v); end
    req0 = 1'b0; req1 = 1'b0;
    repeat (LAT + 1) @(negedge clk);
  endtask

  task automatic test_persist;
    req1 = 1'b1; op1 = 2'b11; a1 = 4'b0000; b1 = 4'b0000;
    for (int k = 0; k < LAT + 5; k++) begin
      @(negedge clk);
      exp_v = {1'b0, k < LAT, 1'b0, k == LAT, k <= LAT, (k >= LAT) ? 4'b1111 : 4'h0};
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL persist cycle %0d: got %b want %b", k, obs, exp_v); end
      req1 = 1'b0;
    end
  endtask

  task automatic test_random;
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      exp_v = {m_ph >= 0 && m_ph < LAT && !m_who, m_ph >= 0 && m_ph < LAT && m_who,
               m_ph == LAT && !m_who, m_ph == LAT && m_who, m_ph >= 0, m_out};
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL random cycle %0d: got %b want %b", k, obs, exp_v); end
      checks++;
      if ((gnt0 && gnt1) || (done0 && done1)) begin errors++; $display("FAIL exclusive cycle %0d: got %b want one-hot", k, obs); end
      reset = $urandom_range(0, 49) == 0;
      req0 = $urandom_range(0, 2) != 0;
      req1 = $urandom_range(0, 2) != 0;
      op0 = 2'($urandom); op1 = 2'($urandom);
      a0 = W'($urandom); b0 = W'($urandom);
      a1 = W'($urandom); b1 = W'($urandom);
    end
    reset = 1'b0; req0 = 1'b0; req1 = 1'b0;
  endtask

  initial begin
    test_reset;
    test_nand;
    test_both;
    test_input_change;
    test_reset_mid;
    test_persist;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
